xpb_table_writer: RTL



---
 rtl/xpb_table_writer_pkg.sv | 15 +
 rtl/xpb_table_writer_mod_add.sv | 20 ++
 rtl/xpb_table_writer.sv | 89 ++++++++
 3 files changed

// File: rtl/xpb_table_writer_pkg.sv
// Shared definitions for the XPB reduction table generator.
// This file holds the default table geometry and the generator state encoding.
package xpb_table_writer_pkg;

    localparam int XPB_DATA_W  = 1024;
    localparam int XPB_DIGIT_W = 5;
    localparam int TABLE_DEPTH = 2 ** XPB_DIGIT_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT   = 2'd1,
        FINISH = 2'd2
    } xpb_state_t;

endpackage

// File: rtl/xpb_table_writer_mod_add.sv
// Combinational modular addition (a + b) mod m with a single conditional subtract.
// The result is only correct when a < m and b < m.
module mod_add_cond_sub #(
    parameter int W = 1024
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] m,
    output logic [W-1:0] sum
);

    logic [W:0]   s;
    logic [W-1:0] t;

    // t only needs the low W bits of s - m; s[W] still takes part in the compare.
    assign s   = {1'b0, a} + {1'b0, b};
    assign t   = s[W-1:0] - m;
    assign sum = (s >= {1'b0, m}) ? t : s[W-1:0];

endmodule

// File: rtl/xpb_table_writer.sv
// Streams the XPB lookup table j*B mod M, j = 0 .. 2^DIGIT_W-1, over a valid/ready port.
// Each entry is built from the previous one by a single modular addition of B.
module xpb_table_writer
    import xpb_table_writer_pkg::*;
#(
    parameter int DATA_W  = XPB_DATA_W,
    parameter int DIGIT_W = XPB_DIGIT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DATA_W-1:0]  base_in,
    input  logic [DATA_W-1:0]  modulus_in,
    output logic               busy,
    output logic               done,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [DIGIT_W-1:0] wr_addr,
    output logic [DATA_W-1:0]  wr_data
);

    localparam logic [DIGIT_W-1:0] LAST_ADDR = '1;

    xpb_state_t        state;
    logic [DATA_W-1:0] base_q;
    logic [DATA_W-1:0] mod_q;
    logic [DATA_W-1:0] next_acc;

    // wr_data doubles as the running accumulator j*B mod M.
    mod_add_cond_sub #(.W(DATA_W)) u_mod_add (
        .a   (wr_data),
        .b   (base_q),
        .m   (mod_q),
        .sum (next_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            base_q   <= '0;
            mod_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        base_q   <= base_in;
                        mod_q    <= modulus_in;
                        wr_data  <= '0;
                        wr_addr  <= '0;
                        wr_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (wr_valid && wr_ready) begin
                        if (wr_addr == LAST_ADDR) begin
                            wr_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            wr_data <= next_acc;
                            wr_addr <= wr_addr + DIGIT_W'(1);
                        end
                    end
                end
                FINISH: begin
                    // Start is deliberately not sampled here, so a request on this edge is dropped.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    wr_valid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
